imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters.
- Port F is the core fetch path and is read-only.
- Port L is the program loader/debug path and can read or write.
- Fetch has priority, a starvation counter forces loader access, and an out-of-range address check protects the array.

Parameters:
DEPTH_LOG2, 10, log2 of the memory depth in 32-bit words (1024 words)
STARVE_MAX, 4, consecutive denied loader cycles before the arbiter switches to the LOAD state
BURST_MAX, 8, maximum loader grants per LOAD visit before returning to RUN

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
f_req  in  1  fetch request
f_addr  in  32  fetch byte address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  f_rdata valid
f_rdata  out  32  fetch read data
l_req  in  1  loader request
l_we  in  1  loader write (1) / read (0)
l_addr  in  32  loader byte address
l_wdata  in  32  loader write data
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  l_rdata valid
l_rdata  out  32  loader read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  DEPTH_LOG2  word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid 1 cycle after mem_en
oor_err  out  1  sticky: an access hit an out-of-range address

Behaviour:
- Reset is synchronous: while rst=1, f_gnt, l_gnt, mem_en, mem_we, f_rvalid, l_rvalid and oor_err are 0.
- Reset also clears f_rdata, l_rdata, mem_addr and mem_wdata to 0, sets state to RUN, and clears both counters.
- Word address is addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored.
- In range means addr[31:DEPTH_LOG2+2]==0.
- Grant is combinational from the current requests and state. At most one of f_gnt/l_gnt is 1 in any cycle.
- A granted in-range access drives mem_en=1 and mem_addr in the same cycle. mem_we=1 only for a loader write; mem_wdata=l_wdata.
- A granted out-of-range access gives mem_en=0 and sets oor_err.
  - Reads still complete, with rdata=0.
  - Writes are dropped.
- Read latency is exactly 1 cycle after grant.
  - Registered flags steer the result to the granted port: f_rvalid or l_rvalid pulses for one cycle.
  - rdata = mem_rdata (in range) or 0 (out of range).
  - rdata holds its last value otherwise.
- Writes never produce rvalid.
- State RUN:
  - f_req=1: fetch granted.
  - f_req=0 and l_req=1: loader granted.
  - starve_cnt increments when l_req=1 and l_gnt=0; it clears when l_gnt=1 or l_req=0.
  - When starve_cnt reaches STARVE_MAX, the next state is LOAD and starve_cnt clears.
- State LOAD:
  - l_req=1: loader granted.
  - l_req=0 and f_req=1: fetch granted.
  - burst_cnt increments on each l_gnt.
  - Return to RUN when l_req=0, or when the grant that makes burst_cnt reach BURST_MAX completes. burst_cnt clears on exit.
- With no requests: no grant, mem_en=0, state unchanged.
- Counters saturate and never wrap.
- Reset mid-operation: a read granted in the cycle before rst rises produces no rvalid. The pipeline flag clears with reset.
- oor_err clears only on rst.

Test Plan:
- Fetch only, f_addr=0x0,0x4,0x8 on consecutive cycles, memory preloaded with 0x00500093/0x00A00113/0x002081B3 -> f_gnt=1 each cycle; mem_addr=0,1,2; f_rvalid one cycle later with those words in order.
- Loader write l_addr=0x10, l_wdata=0xDEADBEEF, f_req=0 -> l_gnt=1, mem_we=1, mem_addr=4, no rvalid. Loader read of 0x10 next cycle -> l_rvalid=1, l_rdata=0xDEADBEEF on the following cycle.
- f_req and l_req held continuously -> fetch granted 4 cycles, then LOAD, loader granted 8 cycles (BURST_MAX), then fetch again. Never both grants high.
- LOAD entered, then l_req dropped after 3 loader grants -> return to RUN the next cycle; fetch granted immediately.
- Loader write to 0x00001000 (word 1024, out of range) -> l_gnt=1, mem_en=0, oor_err=1 and sticky. Fetch read of 0x00001004 -> f_rvalid=1 with f_rdata=0.
- Fetch granted, then rst=1 on the next cycle -> f_rvalid stays 0; all outputs 0; state RUN. Held requests after rst=0 -> normal grant on the first cycle.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous instruction memory.
// Fetch has priority; a starvation counter hands the loader a bounded burst.
module imem_arbiter #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  oor_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  typedef enum logic [0:0] {StRun, StLoad} state_e;

  state_e          r_state;
  logic [SW-1:0]   r_starve;
  logic [BW-1:0]   r_burst;
  logic            r_f_pend;
  logic            r_l_pend;
  logic            r_rd_oor;
  logic            r_oor;
  logic [31:0]     r_f_hold;
  logic [31:0]     r_l_hold;

  logic            w_f_gnt;
  logic            w_l_gnt;
  logic            w_gnt;
  logic [31:0]     w_addr;
  logic            w_in_range;
  logic [31:0]     w_rdata;
  logic [SW-1:0]   w_starve_nxt;
  logic [BW-1:0]   w_burst_nxt;
  logic            w_unused;

  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (!rst) begin
      if (r_state == StRun) begin
        w_f_gnt = f_req;
        w_l_gnt = !f_req && l_req;
      end else begin
        w_l_gnt = l_req;
        w_f_gnt = !l_req && f_req;
      end
    end
  end

  assign w_gnt      = w_f_gnt | w_l_gnt;
  assign w_addr     = w_l_gnt ? l_addr : f_addr;
  assign w_in_range = (w_addr[31:DEPTH_LOG2+2] == '0);
  assign w_unused   = ^{f_addr[1:0], l_addr[1:0]};

  assign f_gnt     = w_f_gnt;
  assign l_gnt     = w_l_gnt;
  assign mem_en    = w_gnt & w_in_range;
  assign mem_we    = w_gnt & w_in_range & w_l_gnt & l_we;
  assign mem_addr  = w_gnt ? w_addr[DEPTH_LOG2+1:2] : '0;
  assign mem_wdata = rst ? 32'h0 : l_wdata;

  // Out-of-range reads complete with zero data instead of stale memory output.
  assign w_rdata  = r_rd_oor ? 32'h0 : mem_rdata;
  assign f_rvalid = r_f_pend & !rst;
  assign l_rvalid = r_l_pend & !rst;
  assign f_rdata  = rst ? 32'h0 : (r_f_pend ? w_rdata : r_f_hold);
  assign l_rdata  = rst ? 32'h0 : (r_l_pend ? w_rdata : r_l_hold);
  assign oor_err  = r_oor & !rst;

  assign w_starve_nxt = (r_starve == STARVE_LIM) ? r_starve : r_starve + 1'b1;
  assign w_burst_nxt  = (r_burst == BURST_LIM) ? r_burst : r_burst + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StRun;
      r_starve <= '0;
      r_burst  <= '0;
      r_f_pend <= 1'b0;
      r_l_pend <= 1'b0;
      r_rd_oor <= 1'b0;
      r_oor    <= 1'b0;
      r_f_hold <= 32'h0;
      r_l_hold <= 32'h0;
    end else begin
      r_f_pend <= w_f_gnt;
      r_l_pend <= w_l_gnt & !l_we;
      r_rd_oor <= !w_in_range;
      if (w_gnt && !w_in_range) begin
        r_oor <= 1'b1;
      end
      if (r_f_pend) begin
        r_f_hold <= w_rdata;
      end
      if (r_l_pend) begin
        r_l_hold <= w_rdata;
      end

      case (r_state)
        StRun: begin
          r_burst <= '0;
          if (l_req && !w_l_gnt) begin
            if (w_starve_nxt == STARVE_LIM) begin
              r_state  <= StLoad;
              r_starve <= '0;
            end else begin
              r_starve <= w_starve_nxt;
            end
          end else begin
            r_starve <= '0;
          end
        end
        StLoad: begin
          r_starve <= '0;
          if (!l_req) begin
            r_state <= StRun;
            r_burst <= '0;
          end else if (w_burst_nxt == BURST_LIM) begin
            r_state <= StRun;
            r_burst <= '0;
          end else begin
            r_burst <= w_burst_nxt;
          end
        end
        default: begin
          r_state <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Vector-driven bench for imem_arbiter with a behavioural memory and read-data scoreboard.
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        oor_err;

  imem_arbiter #(
    .DEPTH_LOG2(10),
    .STARVE_MAX(4),
    .BURST_MAX (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .oor_err  (oor_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        fr;
    logic [31:0] fa;
    logic        lr;
    logic        lw;
    logic [31:0] la;
    logic [31:0] ld;
    logic        efg;
    logic        elg;
    logic        een;
    logic        ewe;
    logic [9:0]  eaddr;
    logic        eoor;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fq[$];
  logic [31:0] lq[$];
  logic [31:0] last_f = 32'h0;
  logic [31:0] last_l = 32'h0;
  vec_t        vecs[$];

  function automatic vec_t mk(input logic r, input logic fr, input logic [31:0] fa,
                              input logic lr, input logic lw, input logic [31:0] la,
                              input logic [31:0] ld, input logic efg, input logic elg,
                              input logic een, input logic ewe, input logic [9:0] ea,
                              input logic eoor);
    vec_t v;
    v.rst = r; v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.efg = efg; v.elg = elg; v.een = een; v.ewe = ewe; v.eaddr = ea; v.eoor = eoor;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic        exp_v;
    logic [31:0] exp_d;
    rst = v.rst; f_req = v.fr; f_addr = v.fa;
    l_req = v.lr; l_we = v.lw; l_addr = v.la; l_wdata = v.ld;
    @(negedge clk);
    if (v.rst) begin
      fq.delete(); lq.delete(); last_f = 32'h0; last_l = 32'h0;
    end
    exp_v = (fq.size() != 0);
    chk("f_rvalid", {31'h0, f_rvalid}, {31'h0, exp_v});
    if (exp_v) begin
      exp_d = fq.pop_front();
      last_f = exp_d;
    end
    chk("f_rdata", f_rdata, last_f);
    exp_v = (lq.size() != 0);
    chk("l_rvalid", {31'h0, l_rvalid}, {31'h0, exp_v});
    if (exp_v) begin
      exp_d = lq.pop_front();
      last_l = exp_d;
    end
    chk("l_rdata", l_rdata, last_l);
    chk("f_gnt", {31'h0, f_gnt}, {31'h0, v.efg});
    chk("l_gnt", {31'h0, l_gnt}, {31'h0, v.elg});
    chk("one_gnt", {31'h0, f_gnt & l_gnt}, 32'h0);
    chk("mem_en", {31'h0, mem_en}, {31'h0, v.een});
    chk("mem_we", {31'h0, mem_we}, {31'h0, v.ewe});
    if (v.een) chk("mem_addr", {22'h0, mem_addr}, {22'h0, v.eaddr});
    if (v.ewe) chk("mem_wdata", mem_wdata, v.ld);
    chk("oor_err", {31'h0, oor_err}, {31'h0, v.eoor});
    if (v.efg) fq.push_back((v.fa[31:12] != 0) ? 32'h0 : ref_mem[v.fa[11:2]]);
    if (v.elg) begin
      if (v.lw) begin
        if (v.la[31:12] == 0) ref_mem[v.la[11:2]] = v.ld;
      end else begin
        lq.push_back((v.la[31:12] != 0) ? 32'h0 : ref_mem[v.la[11:2]]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[0] = 32'h00500093; mem[1] = 32'h00A00113; mem[2] = 32'h002081B3;
    ref_mem[0] = 32'h00500093; ref_mem[1] = 32'h00A00113; ref_mem[2] = 32'h002081B3;
    rst = 1'b1; f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;

    // Reset, fetch stream, loader write/read.
    vecs.push_back(mk(1, 1, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 10'd0, 0));
    vecs.push_back(mk(0, 1, 32'h0, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 10'd0, 0));
    vecs.push_back(mk(0, 1, 32'h4, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 10'd1, 0));
    vecs.push_back(mk(0, 1, 32'h8, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 10'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 1, 1, 1, 10'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h10, 32'h0,        0, 1, 1, 0, 10'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 10'd0, 0));
    // Contention: 4 fetch grants, 8-grant loader burst, then fetch again.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 32'h8, 1, 0, 32'h10, 32'h0, 1, 0, 1, 0, 10'd2, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 32'h8, 1, 0, 32'h10, 32'h0, 0, 1, 1, 0, 10'd4, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 32'h8, 1, 0, 32'h10, 32'h0, 1, 0, 1, 0, 10'd2, 0));
    // Early exit from LOAD after 3 grants.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 32'h8, 1, 0, 32'h10, 32'h0, 0, 1, 1, 0, 10'd4, 0));
    vecs.push_back(mk(0, 1, 32'h8, 0, 0, 32'h0,  32'h0, 1, 0, 1, 0, 10'd2, 0));
    vecs.push_back(mk(0, 1, 32'h8, 1, 0, 32'h10, 32'h0, 1, 0, 1, 0, 10'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 10'd0, 0));
    // Out-of-range write dropped, out-of-range read returns zero, sticky error.
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 32'h1000, 32'h12345678, 0, 1, 0, 0, 10'd0, 0));
    vecs.push_back(mk(0, 1, 32'h1004, 0, 0, 32'h0,    32'h0,        1, 0, 0, 0, 10'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 10'd0, 1));
    vecs.push_back(mk(0, 1, 32'h0,    0, 0, 32'h0,    32'h0,        1, 0, 1, 0, 10'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 10'd0, 1));

    foreach (vecs[i]) step(vecs[i]);

    // Reset one cycle after a fetch grant: no rvalid, everything cleared.
    step(mk(0, 1, 32'h4, 0, 0, 32'h0,  32'h0, 1, 0, 1, 0, 10'd1, 1));
    step(mk(1, 1, 32'h4, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 10'd0, 0));
    step(mk(0, 1, 32'h8, 1, 0, 32'h10, 32'h0, 1, 0, 1, 0, 10'd2, 0));
    step(mk(0, 0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 10'd0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
